// File: rtl/icm_buffer_set_thread.sv
// Write-side thread of the 2-way ICM buffer: fills hit/invalid/LRU way, updates LRU, exports displaced lines.
// Latency: ready and SRAM write 1 cycle after valid is seen; 2 cycles/request, 3+ when a line is evicted.
// Backpressure: requester holds valid/head/data until ready; EVICT stalls on evict_ready and blocks new requests.
module icm_buffer_set_thread #(
    parameter int CACHE_ENTRY_WIDTH  = 256,
    parameter int CACHE_SET_NUM_LOG  = 10,
    parameter int CACHE_OFFSET_WIDTH = 5,
    parameter int CACHE_TAG_WIDTH    = 6,
    parameter int CACHE_ADDR_WIDTH   = CACHE_TAG_WIDTH + CACHE_SET_NUM_LOG + CACHE_OFFSET_WIDTH
) (
    input  logic                                           clk,
    input  logic                                           rst,
    input  logic                                           set_req_valid,
    input  logic [CACHE_ADDR_WIDTH-1:0]                    set_req_head,
    input  logic [CACHE_ENTRY_WIDTH-1:0]                   set_req_data,
    output logic                                           set_req_ready,
    output logic                                           evict_valid,
    output logic [CACHE_ADDR_WIDTH-1:0]                    evict_head,
    output logic [CACHE_ENTRY_WIDTH-1:0]                   evict_data,
    input  logic                                           evict_ready,
    output logic                                           way_0_wen,
    output logic [CACHE_SET_NUM_LOG-1:0]                   way_0_addr,
    output logic [CACHE_ENTRY_WIDTH+CACHE_TAG_WIDTH:0]     way_0_din,
    input  logic [CACHE_ENTRY_WIDTH+CACHE_TAG_WIDTH:0]     way_0_dout,
    output logic                                           way_1_wen,
    output logic [CACHE_SET_NUM_LOG-1:0]                   way_1_addr,
    output logic [CACHE_ENTRY_WIDTH+CACHE_TAG_WIDTH:0]     way_1_din,
    input  logic [CACHE_ENTRY_WIDTH+CACHE_TAG_WIDTH:0]     way_1_dout,
    output logic                                           lru_wen,
    output logic [CACHE_SET_NUM_LOG-1:0]                   lru_addr,
    output logic                                           lru_din,
    input  logic                                           lru_dout
);

    localparam int LINE_W = CACHE_ENTRY_WIDTH + CACHE_TAG_WIDTH + 1;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_LOOKUP = 2'd1;
    localparam logic [1:0] ST_EVICT  = 2'd2;

    logic [1:0]                   state;
    logic [CACHE_TAG_WIDTH-1:0]   tag_q;
    logic [CACHE_SET_NUM_LOG-1:0] set_q;
    logic [CACHE_ENTRY_WIDTH-1:0] data_q;
    logic [CACHE_ADDR_WIDTH-1:0]  evict_head_q;
    logic [CACHE_ENTRY_WIDTH-1:0] evict_data_q;

    logic [CACHE_TAG_WIDTH-1:0]   req_tag;
    logic [CACHE_SET_NUM_LOG-1:0] req_set;
    logic                         unused_offset;

    assign req_tag       = set_req_head[CACHE_ADDR_WIDTH-1 -: CACHE_TAG_WIDTH];
    assign req_set       = set_req_head[CACHE_OFFSET_WIDTH +: CACHE_SET_NUM_LOG];
    assign unused_offset = ^set_req_head[CACHE_OFFSET_WIDTH-1:0];

    logic                         v0, v1, hit0, hit1, sel, need_evict;
    logic [CACHE_TAG_WIDTH-1:0]   t0, t1, victim_tag;
    logic [CACHE_ENTRY_WIDTH-1:0] d0, d1, victim_data;
    logic [LINE_W-1:0]            new_line;

    assign v0 = way_0_dout[LINE_W-1];
    assign v1 = way_1_dout[LINE_W-1];
    assign t0 = way_0_dout[CACHE_ENTRY_WIDTH +: CACHE_TAG_WIDTH];
    assign t1 = way_1_dout[CACHE_ENTRY_WIDTH +: CACHE_TAG_WIDTH];
    assign d0 = way_0_dout[CACHE_ENTRY_WIDTH-1:0];
    assign d1 = way_1_dout[CACHE_ENTRY_WIDTH-1:0];

    assign hit0 = v0 && (t0 == tag_q);
    assign hit1 = v1 && (t1 == tag_q);

    // Hit beats free slot beats LRU victim; a double hit resolves to way 0.
    always_comb begin
        sel = 1'b0;
        if (hit0)      sel = 1'b0;
        else if (hit1) sel = 1'b1;
        else if (!v0)  sel = 1'b0;
        else if (!v1)  sel = 1'b1;
        else           sel = ~lru_dout;
    end

    // Only a miss with both ways occupied displaces a live line.
    assign need_evict  = !hit0 && !hit1 && v0 && v1;
    assign victim_tag  = sel ? t1 : t0;
    assign victim_data = sel ? d1 : d0;
    assign new_line    = {1'b1, tag_q, data_q};

    always_comb begin
        set_req_ready = 1'b0;
        evict_valid   = 1'b0;
        evict_head    = '0;
        evict_data    = '0;
        way_0_wen     = 1'b0;
        way_1_wen     = 1'b0;
        way_0_addr    = '0;
        way_1_addr    = '0;
        way_0_din     = '0;
        way_1_din     = '0;
        lru_wen       = 1'b0;
        lru_addr      = '0;
        lru_din       = 1'b0;
        // Outputs are forced quiet during reset so no SRAM write can slip through.
        if (!rst) begin
            case (state)
                ST_IDLE: begin
                    if (set_req_valid) begin
                        way_0_addr = req_set;
                        way_1_addr = req_set;
                        lru_addr   = req_set;
                    end
                end
                ST_LOOKUP: begin
                    set_req_ready = 1'b1;
                    way_0_addr    = set_q;
                    way_1_addr    = set_q;
                    lru_addr      = set_q;
                    lru_wen       = 1'b1;
                    lru_din       = sel;
                    if (sel) begin
                        way_1_wen = 1'b1;
                        way_1_din = new_line;
                    end else begin
                        way_0_wen = 1'b1;
                        way_0_din = new_line;
                    end
                end
                ST_EVICT: begin
                    evict_valid = 1'b1;
                    evict_head  = evict_head_q;
                    evict_data  = evict_data_q;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            tag_q        <= '0;
            set_q        <= '0;
            data_q       <= '0;
            evict_head_q <= '0;
            evict_data_q <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (set_req_valid) begin
                        tag_q  <= req_tag;
                        set_q  <= req_set;
                        data_q <= set_req_data;
                        state  <= ST_LOOKUP;
                    end
                end
                ST_LOOKUP: begin
                    if (need_evict) begin
                        evict_head_q <= {victim_tag, set_q, {CACHE_OFFSET_WIDTH{1'b0}}};
                        evict_data_q <= victim_data;
                        state        <= ST_EVICT;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_EVICT: begin
                    if (evict_ready) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_icm_buffer_set_thread.sv
// Randomized scoreboard bench for icm_buffer_set_thread with behavioural SRAM/LRU arrays and a cache model.
module tb_icm_buffer_set_thread;

    localparam int EW = 256;
    localparam int SL = 10;
    localparam int TW = 6;
    localparam int AW = 21;
    localparam int LW = EW + TW + 1;
    localparam int NSETS = 1 << SL;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          set_req_valid = 1'b0;
    logic [AW-1:0] set_req_head = '0;
    logic [EW-1:0] set_req_data = '0;
    logic          set_req_ready;
    logic          evict_valid;
    logic [AW-1:0] evict_head;
    logic [EW-1:0] evict_data;
    logic          evict_ready = 1'b0;
    logic          way_0_wen, way_1_wen, lru_wen, lru_din;
    logic [SL-1:0] way_0_addr, way_1_addr, lru_addr;
    logic [LW-1:0] way_0_din, way_1_din;
    logic [LW-1:0] way_0_dout = '0;
    logic [LW-1:0] way_1_dout = '0;
    logic          lru_dout = 1'b0;

    icm_buffer_set_thread dut (
        .clk(clk), .rst(rst),
        .set_req_valid(set_req_valid), .set_req_head(set_req_head),
        .set_req_data(set_req_data), .set_req_ready(set_req_ready),
        .evict_valid(evict_valid), .evict_head(evict_head),
        .evict_data(evict_data), .evict_ready(evict_ready),
        .way_0_wen(way_0_wen), .way_0_addr(way_0_addr), .way_0_din(way_0_din), .way_0_dout(way_0_dout),
        .way_1_wen(way_1_wen), .way_1_addr(way_1_addr), .way_1_din(way_1_din), .way_1_dout(way_1_dout),
        .lru_wen(lru_wen), .lru_addr(lru_addr), .lru_din(lru_din), .lru_dout(lru_dout)
    );

    always #5 clk = ~clk;

    // Behavioural SRAMs with one-cycle read latency.
    logic [LW-1:0] mem0 [NSETS];
    logic [LW-1:0] mem1 [NSETS];
    logic          lmem [NSETS];

    always @(posedge clk) begin
        if (way_0_wen) mem0[way_0_addr] <= way_0_din;
        if (way_1_wen) mem1[way_1_addr] <= way_1_din;
        if (lru_wen)   lmem[lru_addr]   <= lru_din;
        way_0_dout <= mem0[way_0_addr];
        way_1_dout <= mem1[way_1_addr];
        lru_dout   <= lmem[lru_addr];
    end

    // Reference cache state, per set and way.
    bit            m_valid [NSETS][2];
    logic [TW-1:0] m_tag   [NSETS][2];
    logic [EW-1:0] m_data  [NSETS][2];
    int            m_mru   [NSETS];

    typedef struct { int way; logic [SL-1:0] set; logic [LW-1:0] din; } wr_t;
    typedef struct { logic [AW-1:0] head; logic [EW-1:0] data; } ev_t;
    wr_t wq[$];
    ev_t evq[$];

    int errors = 0;
    int checks = 0;
    int evict_mode = 0;   // 0 random ready, 1 hold low, 2 hold high
    bit prev_evict = 0;

    task automatic chk(input string nm, input logic [299:0] act, input logic [299:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [EW-1:0] rnd256();
        logic [EW-1:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic all_outs();
        return |{set_req_ready, evict_valid, evict_head, evict_data, way_0_wen, way_1_wen,
                 way_0_addr, way_1_addr, way_0_din, way_1_din, lru_wen, lru_addr, lru_din};
    endfunction

    // Model: prefer a way holding the tag, then an empty way, then the least recently used way.
    task automatic model_req(input logic [SL-1:0] s, input logic [TW-1:0] t, input logic [EW-1:0] d,
                             output bit evicts, output ev_t e);
        int w;
        wr_t x;
        w = -1;
        for (int i = 0; i < 2; i++) if (w < 0 && m_valid[s][i] && m_tag[s][i] == t) w = i;
        for (int i = 0; i < 2; i++) if (w < 0 && !m_valid[s][i]) w = i;
        if (w < 0) w = 1 - m_mru[s];
        evicts = m_valid[s][w] && (m_tag[s][w] != t);
        e.head = {m_tag[s][w], s, 5'd0};
        e.data = m_data[s][w];
        x.way = w; x.set = s; x.din = {1'b1, t, d};
        wq.push_back(x);
        m_valid[s][w] = 1'b1;
        m_tag[s][w]   = t;
        m_data[s][w]  = d;
        m_mru[s]      = w;
    endtask

    // abort: 0 normal, 1 reset while in LOOKUP, 2 reset while in EVICT. Returns at posedge+1.
    task automatic send(input logic [AW-1:0] h, input logic [EW-1:0] d, input int abort);
        bit  ev;
        ev_t e;
        int  waits;
        ev = 0;
        if (abort != 1) model_req(h[14:5], h[20:15], d, ev, e);
        if (ev && abort == 0) evq.push_back(e);
        if (abort == 2) evict_mode = 1;
        set_req_valid = 1'b1;
        set_req_head  = h;
        set_req_data  = d;
        waits = 0;
        while (1) begin
            #1;
            if (set_req_ready) break;
            if (!evict_valid)
                chk("idle_addr", 300'({way_0_addr, way_1_addr, lru_addr, way_0_wen, way_1_wen, lru_wen}),
                    300'({h[14:5], h[14:5], h[14:5], 3'b000}));
            if (waits >= 200) begin
                chk("ready_timeout", 300'(waits), 300'(0));
                break;
            end
            @(posedge clk);
            waits++;
        end
        if (!prev_evict) chk("ready_latency", 300'(waits), 300'(1));
        if (abort == 1) begin
            rst = 1'b1;
            #1 chk("rst_lookup_outs", 300'(all_outs()), 300'(0));
            @(posedge clk);
            #1 chk("rst_lookup_hold", 300'(all_outs()), 300'(0));
            set_req_valid = 1'b0;
            rst = 1'b0;
            prev_evict = 0;
            return;
        end
        @(posedge clk);
        #1;
        set_req_valid = 1'b0;
        if (abort == 2) begin
            chk("evict_before_rst", 300'(evict_valid), 300'(1));
            rst = 1'b1;
            #1 chk("rst_evict_outs", 300'(all_outs()), 300'(0));
            @(posedge clk);
            #1 chk("rst_evict_hold", 300'(all_outs()), 300'(0));
            rst = 1'b0;
            evict_mode = 0;
            ev = 0;
        end
        prev_evict = ev;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (evict_mode)
                1:       evict_ready = 1'b0;
                2:       evict_ready = 1'b1;
                default: evict_ready = ($urandom_range(0, 2) == 0);
            endcase
        end
    end

    // Monitor: every SRAM write and every eviction handshake is matched against the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            if (way_0_wen || way_1_wen || lru_wen) begin
                if (wq.size() == 0) begin
                    chk("write_unexpected", 300'(1), 300'(0));
                end else begin
                    wr_t w;
                    w = wq.pop_front();
                    chk("wr_en", 300'({way_0_wen, way_1_wen, lru_wen, set_req_ready}),
                        300'({w.way == 0, w.way == 1, 1'b1, 1'b1}));
                    chk("wr_addr", 300'({way_0_addr, way_1_addr, lru_addr}), 300'({w.set, w.set, w.set}));
                    chk("wr_din", 300'(w.way == 1 ? way_1_din : way_0_din), 300'(w.din));
                    chk("wr_other_din", 300'(w.way == 1 ? way_0_din : way_1_din), 300'(0));
                    chk("lru_din", 300'(lru_din), 300'(w.way == 1));
                end
            end
            if (evict_valid && evict_ready) begin
                if (evq.size() == 0) begin
                    chk("evict_unexpected", 300'(1), 300'(0));
                end else begin
                    ev_t e;
                    e = evq.pop_front();
                    chk("evict_head", 300'(evict_head), 300'(e.head));
                    chk("evict_data", 300'(evict_data), 300'(e.data));
                end
            end
        end
    end

    initial begin
        logic [EW-1:0] d0, d1;
        int            waits;
        for (int i = 0; i < NSETS; i++) begin
            mem0[i] = '0; mem1[i] = '0; lmem[i] = 1'b0;
            m_valid[i][0] = 0; m_valid[i][1] = 0; m_mru[i] = 0;
            m_tag[i][0] = '0; m_tag[i][1] = '0; m_data[i][0] = '0; m_data[i][1] = '0;
        end
        set_req_valid = 1'b1;
        set_req_head  = 21'h1f_ffe0;
        repeat (3) @(posedge clk);
        #1 chk("reset_outs", 300'(all_outs()), 300'(0));
        set_req_valid = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        #1 chk("idle_outs", 300'(all_outs()), 300'(0));

        // Directed fills into set 2: empty fill, second way, hit update, replacement.
        d0 = rnd256();
        send(21'h00_0040, d0, 0);
        chk("fill0_mem", 300'(mem0[2]), 300'({1'b1, 6'h0, d0}));
        chk("fill0_no_evict", 300'(evict_valid), 300'(0));
        send({6'd3, 10'd2, 5'd0}, rnd256(), 0);
        chk("fill1_no_evict", 300'(evict_valid), 300'(0));
        d1 = rnd256();
        send({6'd3, 10'd2, 5'd0}, d1, 0);
        chk("hit_mem1", 300'(mem1[2]), 300'({1'b1, 6'd3, d1}));
        evict_mode = 1;
        send({6'd5, 10'd2, 5'd0}, rnd256(), 0);
        for (int i = 0; i < 4; i++) begin
            chk("evict_held", 300'({evict_valid, evict_head, evict_data}), 300'({1'b1, 21'h00_0040, d0}));
            @(posedge clk);
            #1;
        end
        evict_mode = 2;
        waits = 0;
        while (evict_valid && waits < 10) begin
            @(posedge clk);
            #1;
            waits++;
        end
        chk("evict_released", 300'(evict_valid), 300'(0));
        evict_mode = 0;
        prev_evict = 0;

        // Reset during LOOKUP, then a normal request; reset during EVICT, then a normal request.
        send({6'd9, 10'd7, 5'd3}, rnd256(), 1);
        send({6'd9, 10'd7, 5'd0}, rnd256(), 0);
        send({6'd1, 10'd7, 5'd0}, rnd256(), 0);
        send({6'd2, 10'd7, 5'd0}, rnd256(), 2);
        send({6'd4, 10'd7, 5'd0}, rnd256(), 0);

        // Randomized back-to-back traffic over a few hot sets.
        for (int n = 0; n < 300; n++) begin
            logic [SL-1:0] s;
            logic [TW-1:0] t;
            s = ($urandom_range(0, 7) == 0) ? SL'($urandom_range(0, NSETS - 1)) : SL'($urandom_range(0, 3));
            t = TW'($urandom_range(0, 3));
            send({t, s, 5'($urandom_range(0, 31))}, rnd256(), 0);
        end

        evict_mode = 2;
        waits = 0;
        while (evict_valid && waits < 20) begin
            @(posedge clk);
            #1;
            waits++;
        end
        repeat (3) @(posedge clk);
        #1;
        chk("wq_drained", 300'(wq.size()), 300'(0));
        chk("evq_drained", 300'(evq.size()), 300'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
